// File: rtl/oric_mem_pkg.sv
// Shared definitions for the Oric RAM to SDRAM bridge: default widths,
// FSM state encoding and the SDRAM byte-enable encodings.
package oric_mem_pkg;

    localparam int AW_DEF = 16;
    localparam int DW_DEF = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    localparam logic [1:0] DS_LO = 2'b01;
    localparam logic [1:0] DS_HI = 2'b10;
    localparam logic [1:0] DS_RD = 2'b11;

    // Reads fetch the whole word; writes enable only the addressed byte lane.
    function automatic logic [1:0] ds_encode(input logic we, input logic a0);
        if (!we) begin
            return DS_RD;
        end
        return a0 ? DS_HI : DS_LO;
    endfunction

endpackage

// File: rtl/toggle_hs.sv
// Toggle request/acknowledge handshake. A start pulse flips the request
// line; the transfer is complete on the first cycle the acknowledge equals
// the request again, which is flagged by a one-cycle done pulse. Start may
// coincide with done so back-to-back transfers need no idle cycle.
module toggle_hs (
    input  logic clk_mem,
    input  logic reset,
    input  logic i_start,
    input  logic i_ack,
    output logic o_req,
    output logic o_done
);

    logic r_req;
    logic r_busy;
    logic w_done;

    assign w_done = r_busy & (r_req == i_ack);
    assign o_req  = r_req;
    assign o_done = w_done;

    // Flip the request on start; track whether a transfer is outstanding.
    always_ff @(posedge clk_mem) begin
        if (reset) begin
            r_req  <= 1'b0;
            r_busy <= 1'b0;
        end else if (i_start) begin
            r_req  <= ~r_req;
            r_busy <= 1'b1;
        end else if (w_done) begin
            r_busy <= 1'b0;
        end
    end

endmodule

// File: rtl/oric_sdram_bridge.sv
// Bridges the Oric CPU RAM strobes onto one toggle-handshake SDRAM port.
// Strobes are registered, edge/address-change detected, and turned into
// requests. One request is in flight at a time; a single pending slot
// absorbs a trigger arriving while waiting (a queued read may be replaced,
// a queued write is never discarded, so a further trigger is dropped and
// flagged on the sticky overrun output).
//
// Handshake: a request is presented by toggling port1_req with address,
// data, we and ds already stable; those stay stable until port1_ack equals
// port1_req, which marks completion and validates port1_q.
module oric_sdram_bridge
    import oric_mem_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic            clk_mem,
    input  logic            reset,
    input  logic            ram_cs,
    input  logic            ram_oe,
    input  logic            ram_we,
    input  logic [AW-1:0]   ram_ad,
    input  logic [DW-1:0]   ram_d,
    output logic [DW-1:0]   ram_q,
    output logic            busy,
    output logic            overrun,
    output logic            port1_req,
    input  logic            port1_ack,
    output logic [AW-1:0]   port1_a,
    output logic [1:0]      port1_ds,
    output logic            port1_we,
    output logic [2*DW-1:0] port1_d,
    input  logic [2*DW-1:0] port1_q,
    output state_t          o_dbg_state
);

    logic            r_rd_s, r_wr_s, r_rd_o, r_wr_o;
    logic [AW-1:0]   r_ad_s, r_ad_o;
    logic [DW-1:0]   r_d_s;

    state_t          r_state;
    logic            r_slot_valid;
    logic            r_slot_we;
    logic [AW-1:0]   r_slot_ad;
    logic [DW-1:0]   r_slot_d;
    logic [AW-1:0]   r_port1_a;
    logic [1:0]      r_port1_ds;
    logic            r_port1_we;
    logic [2*DW-1:0] r_port1_d;
    logic [DW-1:0]   r_ram_q;
    logic            r_overrun;

    logic            w_trig;
    logic            w_done;
    logic            w_start;
    logic            w_from_slot;
    logic [AW-1:0]   w_iss_ad;
    logic [DW-1:0]   w_iss_d;
    logic            w_iss_we;

    // Register the strobes once, and keep one more cycle of history.
    always_ff @(posedge clk_mem) begin
        if (reset) begin
            r_rd_s <= 1'b0;
            r_wr_s <= 1'b0;
            r_ad_s <= '0;
            r_d_s  <= '0;
            r_rd_o <= 1'b0;
            r_wr_o <= 1'b0;
            r_ad_o <= '0;
        end else begin
            r_rd_s <= ram_cs & ram_oe;
            r_wr_s <= ram_cs & ram_we;
            r_ad_s <= ram_ad;
            r_d_s  <= ram_d;
            r_rd_o <= r_rd_s;
            r_wr_o <= r_wr_s;
            r_ad_o <= r_ad_s;
        end
    end

    // A new access: rising read/write strobe, or read address moving while held.
    assign w_trig = (r_rd_s & ~r_rd_o) | (r_wr_s & ~r_wr_o)
                  | (r_rd_s & (r_ad_s != r_ad_o));

    // Decide what (if anything) is launched at the coming edge.
    always_comb begin
        w_from_slot = (r_state == ST_WAIT) & w_done & r_slot_valid;
        w_start     = ((r_state == ST_IDLE) & w_trig)
                    | ((r_state == ST_WAIT) & w_done & (r_slot_valid | w_trig));
        w_iss_ad    = r_ad_s;
        w_iss_d     = r_d_s;
        w_iss_we    = r_wr_s;
        if (w_from_slot) begin
            w_iss_ad = r_slot_ad;
            w_iss_d  = r_slot_d;
            w_iss_we = r_slot_we;
        end
    end

    toggle_hs u_hs (
        .clk_mem (clk_mem),
        .reset   (reset),
        .i_start (w_start),
        .i_ack   (port1_ack),
        .o_req   (port1_req),
        .o_done  (w_done)
    );

    // Request FSM: launches requests, captures read data, manages the slot.
    always_ff @(posedge clk_mem) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_slot_valid <= 1'b0;
            r_slot_we    <= 1'b0;
            r_slot_ad    <= '0;
            r_slot_d     <= '0;
            r_port1_a    <= '0;
            r_port1_ds   <= DS_RD;
            r_port1_we   <= 1'b0;
            r_port1_d    <= '0;
            r_ram_q      <= '0;
            r_overrun    <= 1'b0;
        end else begin
            if (w_start) begin
                r_port1_a  <= w_iss_ad;
                r_port1_d  <= {w_iss_d, w_iss_d};
                r_port1_we <= w_iss_we;
                r_port1_ds <= ds_encode(w_iss_we, w_iss_ad[0]);
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_trig) begin
                        r_state <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (w_done) begin
                        if (!r_port1_we) begin
                            r_ram_q <= r_port1_a[0] ? port1_q[2*DW-1:DW] : port1_q[DW-1:0];
                        end
                        if (r_slot_valid) begin
                            // Slot launches now; a simultaneous trigger refills it.
                            r_slot_valid <= w_trig;
                            if (w_trig) begin
                                r_slot_ad <= r_ad_s;
                                r_slot_d  <= r_d_s;
                                r_slot_we <= r_wr_s;
                            end
                        end else if (!w_trig) begin
                            r_state <= ST_IDLE;
                        end
                    end else if (w_trig) begin
                        if (!r_slot_valid || !r_slot_we) begin
                            r_slot_valid <= 1'b1;
                            r_slot_ad    <= r_ad_s;
                            r_slot_d     <= r_d_s;
                            r_slot_we    <= r_wr_s;
                        end else begin
                            r_overrun <= 1'b1;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign port1_a     = r_port1_a;
    assign port1_ds    = r_port1_ds;
    assign port1_we    = r_port1_we;
    assign port1_d     = r_port1_d;
    assign ram_q       = r_ram_q;
    assign overrun     = r_overrun;
    assign busy        = (r_state == ST_WAIT) | r_slot_valid;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_oric_sdram_bridge.sv
// Directed bench for oric_sdram_bridge: the SDRAM controller acknowledge is
// driven by hand, and each step checks hand-computed expected values.
module tb_oric_sdram_bridge;
    import oric_mem_pkg::*;

    // ---------------- clock / reset ----------------
    logic        clk_mem = 1'b0;
    logic        reset;
    always #5 clk_mem = ~clk_mem;

    logic        ram_cs, ram_oe, ram_we;
    logic [15:0] ram_ad;
    logic [7:0]  ram_d;
    logic [7:0]  ram_q;
    logic        busy, overrun;
    logic        port1_req, port1_ack;
    logic [15:0] port1_a;
    logic [1:0]  port1_ds;
    logic        port1_we;
    logic [15:0] port1_d;
    logic [15:0] port1_q;
    state_t      dbg_state;

    int total = 0;
    int bad   = 0;
    int toggles = 0;
    int snap;
    logic req_prev = 1'b0;

    oric_sdram_bridge #(.AW(16), .DW(8)) dut (
        .clk_mem     (clk_mem),
        .reset       (reset),
        .ram_cs      (ram_cs),
        .ram_oe      (ram_oe),
        .ram_we      (ram_we),
        .ram_ad      (ram_ad),
        .ram_d       (ram_d),
        .ram_q       (ram_q),
        .busy        (busy),
        .overrun     (overrun),
        .port1_req   (port1_req),
        .port1_ack   (port1_ack),
        .port1_a     (port1_a),
        .port1_ds    (port1_ds),
        .port1_we    (port1_we),
        .port1_d     (port1_d),
        .port1_q     (port1_q),
        .o_dbg_state (dbg_state)
    );

    // Count every change of the request line, sampled on the falling edge.
    always @(negedge clk_mem) begin
        if (port1_req !== req_prev) toggles++;
        req_prev = port1_req;
    end

    // ---------------- driver / check tasks ----------------
    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk_mem);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_req"},  32'(port1_req), 32'h0);
        check({tag, "_we"},   32'(port1_we),  32'h0);
        check({tag, "_a"},    32'(port1_a),   32'h0);
        check({tag, "_d"},    32'(port1_d),   32'h0);
        check({tag, "_ds"},   32'(port1_ds),  32'h3);
        check({tag, "_ramq"}, 32'(ram_q),     32'h0);
        check({tag, "_busy"}, 32'(busy),      32'h0);
        check({tag, "_ovr"},  32'(overrun),   32'h0);
        check({tag, "_st"},   32'(dbg_state), 32'h0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        reset = 1'b1; ram_cs = 0; ram_oe = 0; ram_we = 0;
        ram_ad = '0; ram_d = '0; port1_ack = 0; port1_q = '0;
        tick(3);
        check_reset_values("rst");
        reset = 1'b0;
        tick();

        // Read 0x1235, ack three cycles after the request.
        ram_cs = 1; ram_oe = 1; ram_ad = 16'h1235;
        tick();
        check("rd_not_yet", 32'(busy), 32'h0);
        tick();
        check("rd_req",  32'(port1_req), 32'h1);
        check("rd_a",    32'(port1_a),   32'h1235);
        check("rd_ds",   32'(port1_ds),  32'h3);
        check("rd_we",   32'(port1_we),  32'h0);
        check("rd_busy", 32'(busy),      32'h1);
        tick(2);
        check("rd_wait_busy", 32'(busy), 32'h1);
        port1_ack = 1; port1_q = 16'hAB12;
        tick();
        check("rd_ramq",  32'(ram_q),     32'hAB);
        check("rd_idle",  32'(busy),      32'h0);
        check("rd_state", 32'(dbg_state), 32'h0);
        ram_cs = 0; ram_oe = 0;
        tick();

        // Write 0x5A to 0x0400: low lane, duplicated data, one toggle.
        snap = toggles;
        ram_cs = 1; ram_we = 1; ram_ad = 16'h0400; ram_d = 8'h5A;
        tick(2);
        check("wr_req", 32'(port1_req), 32'h0);
        check("wr_ds",  32'(port1_ds),  32'h1);
        check("wr_d",   32'(port1_d),   32'h5A5A);
        check("wr_we",  32'(port1_we),  32'h1);
        check("wr_a",   32'(port1_a),   32'h0400);
        tick(2);
        check("wr_one_toggle", 32'(toggles - snap), 32'h1);
        port1_ack = 0;
        tick();
        check("wr_idle", 32'(busy),  32'h0);
        check("wr_ramq", 32'(ram_q), 32'hAB);
        ram_cs = 0; ram_we = 0;
        tick();

        // Held read with the address moving each cycle; slot keeps the latest.
        snap = toggles;
        ram_cs = 1; ram_oe = 1; ram_ad = 16'h0010;
        tick();
        ram_ad = 16'h0011;
        tick();
        check("mv_a0", 32'(port1_a), 32'h0010);
        ram_ad = 16'h0012;
        tick();
        ram_ad = 16'h0013;
        tick(3);
        check("mv_a_stable", 32'(port1_a),   32'h0010);
        check("mv_req_held", 32'(port1_req), 32'h1);
        port1_ack = 1; port1_q = 16'h3344;
        tick();
        check("mv_ramq1",  32'(ram_q),     32'h44);
        check("mv_slot_a", 32'(port1_a),   32'h0013);
        check("mv_req2",   32'(port1_req), 32'h0);
        check("mv_busy",   32'(busy),      32'h1);
        port1_ack = 0; port1_q = 16'h5566;
        tick();
        check("mv_ramq2",   32'(ram_q),          32'h55);
        check("mv_idle",    32'(busy),           32'h0);
        check("mv_toggles", 32'(toggles - snap), 32'h2);
        ram_cs = 0; ram_oe = 0;
        tick();

        // Write in flight, write queued, third write dropped.
        ram_cs = 1; ram_we = 1; ram_ad = 16'h0020; ram_d = 8'h11;
        tick();
        ram_we = 0;
        tick();
        check("ov_a1", 32'(port1_a), 32'h0020);
        ram_we = 1; ram_ad = 16'h0021; ram_d = 8'h22;
        tick();
        ram_we = 0;
        tick();
        check("ov_clear", 32'(overrun), 32'h0);
        ram_we = 1; ram_ad = 16'h0022; ram_d = 8'h33;
        tick();
        ram_we = 0;
        tick();
        check("ov_set",  32'(overrun), 32'h1);
        check("ov_a1b",  32'(port1_a), 32'h0020);
        check("ov_d1",   32'(port1_d), 32'h1111);
        port1_ack = 1;
        tick();
        check("ov_a2",   32'(port1_a),   32'h0021);
        check("ov_d2",   32'(port1_d),   32'h2222);
        check("ov_req2", 32'(port1_req), 32'h0);
        port1_ack = 0;
        tick();
        check("ov_idle",   32'(busy),     32'h0);
        check("ov_a_last", 32'(port1_a),  32'h0021);
        check("ov_sticky", 32'(overrun),  32'h1);
        ram_cs = 0;
        tick();

        // Reset while waiting abandons the request.
        ram_cs = 1; ram_oe = 1; ram_ad = 16'h0031;
        tick(2);
        check("rw_req", 32'(port1_req), 32'h1);
        reset = 1; ram_cs = 0; ram_oe = 0;
        tick();
        check_reset_values("rw");
        reset = 0;
        tick();
        ram_cs = 1; ram_oe = 1; ram_ad = 16'h0041;
        tick(2);
        check("rw_new_req", 32'(port1_req), 32'h1);
        check("rw_new_a",   32'(port1_a),   32'h0041);
        port1_ack = 1; port1_q = 16'h7788;
        tick();
        check("rw_new_ramq", 32'(ram_q), 32'h77);
        check("rw_new_idle", 32'(busy),  32'h0);
        ram_cs = 0; ram_oe = 0;
        tick();

        // Read and write rise together: a single write wins.
        snap = toggles;
        ram_cs = 1; ram_oe = 1; ram_we = 1; ram_ad = 16'h0050; ram_d = 8'h99;
        tick(2);
        check("rw2_we", 32'(port1_we), 32'h1);
        check("rw2_ds", 32'(port1_ds), 32'h1);
        check("rw2_d",  32'(port1_d),  32'h9999);
        tick(2);
        check("rw2_one", 32'(toggles - snap), 32'h1);
        port1_ack = 0;
        tick();
        check("rw2_idle", 32'(busy),  32'h0);
        check("rw2_ramq", 32'(ram_q), 32'h77);
        tick(2);
        check("rw2_no_more", 32'(toggles - snap), 32'h1);
        ram_cs = 0; ram_oe = 0; ram_we = 0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
